// File: rtl/fir_mac_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : fir_mac_sequencer_if
// Purpose  : Sample-in, coefficient ROM and result-out signals of the FIR MAC engine.
// Revision : 1.0 - initial release
// ============================================================================
interface fir_mac_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int COEF_W = 8,
  parameter int ACC_W  = 20
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [ADDR_W-1:0] coef_addr;
  logic [COEF_W-1:0] coef_data;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;

  // master: the surrounding system (sample source, ROM, result sink)
  modport master (
    output in_valid, in_data, coef_data, out_ready,
    input  in_ready, coef_addr, out_valid, out_data
  );

  // slave: the MAC sequencer itself
  modport slave (
    input  in_valid, in_data, coef_data, out_ready,
    output in_ready, coef_addr, out_valid, out_data
  );
endinterface
`default_nettype wire

// File: rtl/fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fir_mac_sequencer
// Purpose  : Serial MAC for a TAPS-tap FIR; walks the coefficient ROM once per
//            sample. Optional macro FIR_SAT_OUT_EN: round/saturate the output.
// Revision : 1.0 - initial release
// ============================================================================
module fir_mac_sequencer #(
  parameter int TAPS      = 16,
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int COEF_W    = 8,
  parameter int ACC_W     = 20,
  parameter int OUT_SHIFT = 7
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  fir_mac_sequencer_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MAC   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  localparam int              PROD_W   = DATA_W + COEF_W;
  localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(TAPS - 1);

  if (TAPS > (1 << ADDR_W)) begin : g_chk_addr
    $error("ADDR_W too narrow for TAPS");
  end
  if (ACC_W <= PROD_W || OUT_SHIFT < 1 || OUT_SHIFT >= ACC_W) begin : g_chk_width
    $error("ACC_W/OUT_SHIFT inconsistent with product width");
  end

  logic [1:0]               state_q, state_d;
  logic [DATA_W-1:0]        x_q [TAPS];
  logic [DATA_W-1:0]        x_d [TAPS];
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [ADDR_W-1:0]        tap_q, tap_d;
  logic                     tap_vld_q, tap_vld_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [ACC_W-1:0]  out_data_q, out_data_d;

  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_acc_sum;
  logic signed [ACC_W-1:0]  w_result;

  // tap_q trails addr_q by one cycle so it lines up with the ROM read data
  assign w_prod    = $signed(x_q[tap_q]) * $signed(bus.coef_data);
  assign w_acc_sum = acc_q + {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};

`ifdef FIR_SAT_OUT_EN
  localparam logic signed [ACC_W-1:0] RND_C   = ACC_W'(1 << (OUT_SHIFT - 1));
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [ACC_W-1:0] w_round;
  assign w_round  = (w_acc_sum + RND_C) >>> OUT_SHIFT;
  assign w_result = (w_round > SAT_MAX) ? SAT_MAX :
                    (w_round < SAT_MIN) ? SAT_MIN : w_round;
`else
  assign w_result = w_acc_sum;
`endif

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    acc_d       = acc_q;
    addr_d      = addr_q;
    tap_d       = addr_q;
    tap_vld_d   = (state_q == S_MAC);
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (tap_vld_q) begin
      acc_d = w_acc_sum;
    end

    case (state_q)
      S_IDLE: begin
        in_ready_d = 1'b1;
        if (bus.in_valid && in_ready_q) begin
          x_d[0] = bus.in_data;
          for (int k = 1; k < TAPS; k++) begin
            x_d[k] = x_q[k-1];
          end
          acc_d      = '0;
          in_ready_d = 1'b0;
          state_d    = S_MAC;
        end
      end
      S_MAC: begin
        if (addr_q == LAST_TAP) begin
          addr_d  = '0;
          state_d = S_DRAIN;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_DRAIN: begin
        // last product is folded in here so the result registers with out_valid
        out_valid_d = 1'b1;
        out_data_d  = w_result;
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      for (int k = 0; k < TAPS; k++) begin
        x_q[k] <= '0;
      end
      acc_q       <= '0;
      addr_q      <= '0;
      tap_q       <= '0;
      tap_vld_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      acc_q       <= acc_d;
      addr_q      <= addr_d;
      tap_q       <= tap_d;
      tap_vld_q   <= tap_vld_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.coef_addr = addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_mac_sequencer
// Purpose  : Directed self-checking bench for fir_mac_sequencer with a
//            1-cycle registered coefficient ROM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_mac_sequencer;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  logic signed [7:0] rom [16];

  fir_mac_sequencer_if bus ();

  fir_mac_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) bus.coef_data <= rom[bus.coef_addr];

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint exp_out(input longint acc);
`ifdef FIR_SAT_OUT_EN
    longint r;
    r = (acc + 64) >>> 7;
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
    return r;
`else
    return acc;
`endif
  endfunction

  task automatic wait_in_ready(input string tag);
    int t;
    t = 0;
    while (!bus.in_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    check({tag, " in_ready_wait"}, bus.in_ready, 1);
  endtask

  // One sample through the engine; optionally stall the result for 'stall' cycles
  task automatic run_sample(input logic signed [7:0] d, input longint acc_exp,
                            input int stall, input string tag);
    int lat;
    logic [19:0] held;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    wait_in_ready(tag);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      check($sformatf("%s addr c%0d", tag, lat), bus.coef_addr,
            (lat <= 16) ? lat - 1 : 0);
      check($sformatf("%s busy_ready c%0d", tag, lat), bus.in_ready, 0);
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, lat, 18);
    check({tag, " out_data"}, $signed(bus.out_data), exp_out(acc_exp));
    held = bus.out_data;
    for (int s = 0; s < stall; s++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'sd7;
      @(negedge clk);
      check($sformatf("%s stall_valid s%0d", tag, s), bus.out_valid, 1);
      check($sformatf("%s stall_ready s%0d", tag, s), bus.in_ready, 0);
      check($sformatf("%s stall_hold s%0d", tag, s), bus.out_data, held);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check({tag, " post_valid"}, bus.out_valid, 0);
    check({tag, " post_ready"}, bus.in_ready, 1);
  endtask

  initial begin
    int  t;
    logic seen;
    n_checks     = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'sd5;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 16; k++) rom[k] = 8'(k + 1);

    // Reset held for 3 cycles with in_valid asserted
    repeat (3) begin
      @(negedge clk);
      check("rst in_ready", bus.in_ready, 0);
      check("rst out_valid", bus.out_valid, 0);
      check("rst coef_addr", bus.coef_addr, 0);
      check("rst out_data", bus.out_data, 0);
    end
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("rel in_ready", bus.in_ready, 1);
    check("rel out_valid", bus.out_valid, 0);

    // Impulse response with c[k]=k+1
    run_sample(8'sd1, 1, 0, "imp0");
    for (int i = 1; i <= 16; i++)
      run_sample(8'sd0, (i < 16) ? i + 1 : 0, 0, $sformatf("imp%0d", i));

    // Extremes, last one with 10 cycles of backpressure
    for (int k = 0; k < 16; k++) rom[k] = -8'sd128;
    for (int n = 1; n <= 16; n++)
      run_sample(-8'sd128, longint'(n) * 16384, (n == 16) ? 10 : 0,
                 $sformatf("ext%0d", n));
    run_sample(8'sd0, 15 * 16384, 0, "bp_after");

    // Reset in the middle of the MAC sweep
    for (int k = 0; k < 16; k++) rom[k] = 8'(k + 1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'sd9;
    wait_in_ready("mid");
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    t = 0;
    while (bus.coef_addr != 4'd7 && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("mid addr7_reached", bus.coef_addr, 7);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid rst in_ready", bus.in_ready, 0);
    check("mid rst coef_addr", bus.coef_addr, 0);
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check("mid no_out_valid", seen, 0);
    run_sample(8'sd1, 1, 0, "post_rst0");
    run_sample(8'sd0, 2, 0, "post_rst1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
